// File: rtl/interrupt_controller.sv
// 8-source memory-mapped interrupt controller: edge-detects peripheral events into
// pending flags, masks and priority-encodes them, and runs an irq/ack/done handshake.
module interrupt_controller #(
  parameter logic [7:0] BASE_ADDR  = 8'h10,
  parameter logic [7:0] RESET_MASK = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic [7:0] address,
  input  logic       w_en,
  input  logic       r_en,
  output logic [7:0] dout,
  input  logic [7:0] irq_src,
  output logic       irq,
  output logic [2:0] irq_vector,
  input  logic       irq_ack,
  input  logic       irq_done
);

  localparam int unsigned NSRC = 8;
  localparam int unsigned VW   = 3;

  localparam logic [1:0] OFS_IMASK = 2'd0;
  localparam logic [1:0] OFS_IFLAG = 2'd1;
  localparam logic [1:0] OFS_ICTRL = 2'd2;
  localparam logic [1:0] OFS_IVEC  = 2'd3;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t          state, state_nxt;
  logic [NSRC-1:0] src_q, iflag, imask;
  logic            gie;
  logic [NSRC-1:0] events, active, sw_clr, ack_clr;
  logic [VW-1:0]   winner, vec_nxt;
  logic            irq_nxt;
  logic [7:0]      offset, rdata;
  logic            hit, wr_hit, rd_hit, in_service;

  // Register window decode
  assign offset = address - BASE_ADDR;
  assign hit    = (offset[7:2] == 6'd0);
  assign wr_hit = w_en & hit;
  assign rd_hit = r_en & hit;

  assign events     = irq_src & ~src_q;
  assign active     = iflag & imask;
  assign in_service = (state == SERVICE);

  assign sw_clr  = (wr_hit && offset[1:0] == OFS_IFLAG) ? din : '0;
  assign ack_clr = (state == REQ && irq_ack) ? (NSRC'(1) << irq_vector) : '0;

  // Lowest set index of the active set wins
  always_comb begin
    winner = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (active[i]) winner = VW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      irq        <= 1'b0;
      irq_vector <= '0;
    end else begin
      state      <= state_nxt;
      irq        <= irq_nxt;
      irq_vector <= vec_nxt;
    end
  end

  // Handshake FSM; irq is asserted exactly while the registered state is REQ
  always_comb begin
    state_nxt = state;
    vec_nxt   = irq_vector;
    irq_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (gie && (active != '0)) begin
          state_nxt = REQ;
          vec_nxt   = winner;
          irq_nxt   = 1'b1;
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_nxt = SERVICE;
        end else if (!gie || !active[irq_vector]) begin
          state_nxt = IDLE;
        end else begin
          irq_nxt = 1'b1;
        end
      end
      SERVICE: begin
        if (irq_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Event set wins over software and acknowledge clears in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q <= '0;
      iflag <= '0;
      imask <= RESET_MASK;
      gie   <= 1'b0;
    end else begin
      src_q <= irq_src;
      iflag <= (iflag & ~(sw_clr | ack_clr)) | events;
      if (wr_hit && offset[1:0] == OFS_IMASK) imask <= din;
      if (wr_hit && offset[1:0] == OFS_ICTRL) gie <= din[0];
    end
  end

  always_comb begin
    rdata = '0;
    case (offset[1:0])
      OFS_IMASK: rdata = imask;
      OFS_IFLAG: rdata = iflag;
      OFS_ICTRL: rdata = {6'd0, in_service, gie};
      OFS_IVEC:  rdata = {irq, 4'd0, irq_vector};
      default:   rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)         dout <= '0;
    else if (rd_hit) dout <= rdata;
  end

endmodule
